// File: rtl/sigmoid_scheduler.sv
// Round-robin scheduler sharing one stochastic sigmoid unit among NUM_REQ requesters.
// Optional SIGMOID_THRESH_EN adds result_bit, a binarised (count >= half window) decision.
module sigmoid_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int WINDOW     = 256,
  parameter int WARMUP_LEN = 16,
  parameter int FLUSH_LEN  = 2,
  parameter int CNT_W      = $clog2(WINDOW + 1),
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_bit,
  output logic [NUM_REQ-1:0] grant,
  output logic               sig_x,
  output logic               sig_n_rst,
  input  logic               sig_y,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [CNT_W-1:0]   result_data,
  output logic [ID_W-1:0]    result_id
`ifdef SIGMOID_THRESH_EN
  ,
  output logic               result_bit
`endif
);

  localparam int MAX_LEN_A = (WINDOW > WARMUP_LEN) ? WINDOW : WARMUP_LEN;
  localparam int MAX_LEN   = (MAX_LEN_A > FLUSH_LEN) ? MAX_LEN_A : FLUSH_LEN;
  localparam int CYC_W     = $clog2(MAX_LEN + 1);
  localparam int FLUSH_LAST = FLUSH_LEN - 1;
  localparam int WARM_LAST  = (WARMUP_LEN > 0) ? WARMUP_LEN - 1 : 0;
  localparam int ACC_LAST   = WINDOW - 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_WARMUP = 3'd2,
    S_ACCUM  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // state_q is the FSM observation point for bound checkers.
  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;

  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W-1:0]      cand;
  logic [ID_W-1:0]      ptr_nxt;

  // Scan from the pointer upward with wrap; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    ptr_nxt = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
  end

`ifdef SIGMOID_THRESH_EN
  localparam int THRESH = (WINDOW + 1) / 2;
  logic bit_q, bit_d;
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef SIGMOID_THRESH_EN
    bit_d   = bit_q;
`endif
    sig_x   = 1'b0;
    busy    = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        if (win_found) begin
          state_d = S_FLUSH;
          grant_d = NUM_REQ'(1) << win_idx;
          id_d    = win_idx;
          ptr_d   = ptr_nxt;
        end
      end
      S_FLUSH: begin
        cnt_d = '0;
`ifdef SIGMOID_THRESH_EN
        bit_d = 1'b0;
`endif
        if (cyc_q == CYC_W'(FLUSH_LAST)) begin
          cyc_d   = '0;
          state_d = (WARMUP_LEN == 0) ? S_ACCUM : S_WARMUP;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_WARMUP: begin
        sig_x = req_bit[id_q];
        if (cyc_q == CYC_W'(WARM_LAST)) begin
          cyc_d   = '0;
          state_d = S_ACCUM;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_ACCUM: begin
        sig_x = req_bit[id_q];
        if (sig_y) cnt_d = cnt_q + CNT_W'(1);
        if (cyc_q == CYC_W'(ACC_LAST)) begin
          cyc_d   = '0;
          state_d = S_DONE;
`ifdef SIGMOID_THRESH_EN
          bit_d   = (cnt_d >= CNT_W'(THRESH));
`endif
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
`ifdef SIGMOID_THRESH_EN
      bit_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
`ifdef SIGMOID_THRESH_EN
      bit_q   <= bit_d;
`endif
    end
  end

  // The unit is held in reset during FLUSH and for as long as rst is high.
  assign sig_n_rst    = ~rst & (state_q != S_FLUSH);
  assign grant        = grant_q;
  assign result_valid = (state_q == S_DONE);
  assign result_data  = cnt_q;
  assign result_id    = id_q;
`ifdef SIGMOID_THRESH_EN
  assign result_bit   = bit_q;
`endif

endmodule

// File: doc/sigmoid_scheduler.md
Name: sigmoid_scheduler

Overview:
- Time-multiplexes one shared stochastic sigmoid unit among NUM_REQ requesters.
- Each job runs as follows: the controller arbitrates round-robin and flushes the sigmoid's internal state through its active-low n_rst. It then routes the winner's input bitstream to the unit, discards WARMUP_LEN settling cycles, and counts ones on the unit output over WINDOW cycles.
- The count is returned with a valid/ready handshake.
- Sits between neuron-layer requesters and a single sigmoid instance.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WINDOW, 256, accumulation length in cycles (>=1)
WARMUP_LEN, 16, settling cycles after flush (0 allowed: state skipped)
FLUSH_LEN, 2, cycles sig_n_rst held low per job (>=1)
CNT_W, $clog2(WINDOW+1), result width (derived)
ID_W, $clog2(NUM_REQ), requester index width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  level request per requester
req_bit  in  NUM_REQ  input bitstream bit per requester
grant  out  NUM_REQ  one-hot; asserted FLUSH through DONE
sig_x  out  1  bitstream to sigmoid x input
sig_n_rst  out  1  active-low reset to sigmoid datapath
sig_y  in  1  sigmoid output bitstream
busy  out  1  high in any state except IDLE
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_data  out  CNT_W  count of ones over WINDOW
result_id  out  ID_W  index of requester served

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; grant, result_valid, result_data and result_id are 0; busy=0; sig_x=0.
  - sig_n_rst=0 while rst is asserted, then 1 in IDLE.
  - Round-robin pointer is 0, so index 0 has highest priority first.
- States: IDLE -> FLUSH -> WARMUP -> ACCUM -> DONE -> IDLE.
- IDLE, with req != 0 at a clock edge:
  - Pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Register grant and result_id; enter FLUSH.
  - Pointer becomes winner+1 mod NUM_REQ.
- FLUSH:
  - sig_n_rst=0 for exactly FLUSH_LEN cycles; cycle counter cleared; ones counter cleared.
  - Then enter WARMUP, or ACCUM if WARMUP_LEN=0.
- WARMUP: sig_n_rst=1 and sig_x=req_bit[result_id]; lasts WARMUP_LEN cycles; sig_y ignored.
- ACCUM:
  - sig_x routed as in WARMUP.
  - For exactly WINDOW cycles, sig_y is sampled each edge and the ones counter increments when it is 1.
  - Counter max is WINDOW; no overflow by construction of CNT_W.
- DONE:
  - result_data is the final count; result_valid=1; sig_x=0; grant held; the sigmoid is not reset.
  - On result_valid & result_ready: clear result_valid and grant; return to IDLE.
  - result_data and result_id hold their values until the next job's FLUSH.
- Latency from req acceptance to result_valid is 1+FLUSH_LEN+WARMUP_LEN+WINDOW cycles, counting the IDLE grant edge.
- Requests:
  - req is level-sensitive and sampled only in IDLE.
  - Deassertion of req mid-job does not abort; the job completes.
  - A new req arriving mid-job waits.
- No back-to-back bypass: at least one IDLE cycle occurs between jobs.
- Simultaneous requests: round-robin guarantees each active requester is served within NUM_REQ jobs.
- rst asserted mid-job aborts immediately to the reset values; the partial count is discarded.
- sig_x is 0 whenever not in WARMUP/ACCUM.

Optional Feature:
- Macro: SIGMOID_THRESH_EN.
- Defined:
  - Adds output port result_bit (1 bit), registered together with result_data.
  - result_bit=1 iff count >= (WINDOW+1)/2 (integer division), giving a binarised neuron decision.
  - Reset value of result_bit is 0.
- Undefined: the port and its comparator are absent; all other behaviour is identical.

Test Plan:
- Bench configuration: NUM_REQ=4, WINDOW=16, WARMUP_LEN=4, FLUSH_LEN=2; bench models sig_y.
- Single job, all ones: req=4'b0010, sig_y tied 1.
  - Required: grant=4'b0010, sig_n_rst low for 2 cycles.
  - Required: result_valid after 23 cycles with result_data=16, result_id=1.
- Warmup exclusion and handshake stall: sig_y=1 only during WARMUP, 0 during ACCUM.
  - Required: result_data=0.
  - With result_ready=0 for 5 cycles, result_valid and grant stay high and data stays stable.
- Round-robin, req=4'b1111 held, ready always 1: grant order 0,1,2,3,0.
  - Required: result_id sequence matches and each job's result_data equals the ones that job drove.
- Routing: req_bit[2] alternates 1/0 and the bench loops sig_y=sig_x.
  - Required: result_data=8 for id 2.
  - Required: sig_x=0 in IDLE, FLUSH and DONE.
- Reset mid-ACCUM: assert rst at the 7th ACCUM cycle.
  - Required: grant=0, busy=0, result_valid=0, sig_n_rst=0 asynchronously.
  - Required: after release, req=4'b0001 completes normally with the pointer restarted at 0.
- SIGMOID_THRESH_EN:
  - count 8 -> result_bit=1.
  - count 7 -> result_bit=0.
